syn_lb_router: RTL and testbench

Parametrised local-bus (LB) router that fans one LB master port out to `NUM_SLAVES` slave LB ports. It decodes the upper address bits into a slave select, registers the request and the response, and tracks the single outstanding transaction with a response timeout. It also generates a stretched per-slave soft-reset pulse when software writes a reserved register address in a slave's window. It sits at the top of each cortex, between the system LB and the sub-block register files, and replaces hand-written per-cortex decode.

---
 rtl/syn_lb_router.sv | 199 +++++++++++++++++++
 tb/tb_syn_lb_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_lb_router.sv
// syn_lb_router: fans one local-bus master out to NUM_SLAVES slave ports.
// Decodes the block code from the upper address bits, registers request and
// response, bounds the single outstanding transaction with a timeout and
// generates stretched per-slave soft-reset pulses from a reserved address.
module syn_lb_router #(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    DATA_W         = 32,
  parameter int                    ADDR_W         = 12,
  parameter int                    SLV_ADDR_W     = 8,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [SLV_ADDR_W-1:0] SRST_REG_ADDR  = 8'hFF,
  parameter int                    SRST_PULSE_W   = 4,
  parameter logic [DATA_W-1:0]     ERR_DATA       = 32'hDEADDEAD
) (
  input  logic                         clk_ir,
  input  logic                         rst_sync,
  input  logic                         lb_rd_en,
  input  logic                         lb_wr_en,
  input  logic [ADDR_W-1:0]            lb_addr,
  input  logic [DATA_W-1:0]            lb_wr_data,
  output logic                         lb_rd_valid,
  output logic                         lb_wr_valid,
  output logic [DATA_W-1:0]            lb_rd_data,
  output logic                         lb_err,
  output logic [NUM_SLAVES-1:0]        slv_rd_en,
  output logic [NUM_SLAVES-1:0]        slv_wr_en,
  output logic [SLV_ADDR_W-1:0]        slv_addr,
  output logic [DATA_W-1:0]            slv_wr_data,
  input  logic [NUM_SLAVES-1:0]        slv_rd_valid,
  input  logic [NUM_SLAVES-1:0]        slv_wr_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data,
  output logic [NUM_SLAVES-1:0]        slv_rst
);

  localparam int CODE_W = ADDR_W - SLV_ADDR_W;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SRST_W = $clog2(SRST_PULSE_W + 1);

  // One extra bit so that NUM_SLAVES == 2**CODE_W is still representable.
  localparam logic [CODE_W:0]   NUM_SLAVES_C = (CODE_W + 1)'(NUM_SLAVES);
  localparam logic [TMO_W-1:0]  TMO_MAX      = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [SRST_W-1:0] SRST_LOAD    = SRST_W'(SRST_PULSE_W);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    is_wr_q;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [SRST_W-1:0]       srst_cnt [NUM_SLAVES];

  logic [CODE_W-1:0]       req_code;
  logic [SLV_ADDR_W-1:0]   req_local;
  logic                    req;
  logic                    code_ok;
  logic                    slv_match;
  logic [DATA_W-1:0]       rd_mux;

  logic accept, fwd, srst_hit, dec_err, slv_hit, tmo_hit;
  logic resp_now, resp_wr, resp_err;

  assign req       = lb_rd_en | lb_wr_en;
  assign req_code  = lb_addr[ADDR_W-1:SLV_ADDR_W];
  assign req_local = lb_addr[SLV_ADDR_W-1:0];
  assign code_ok   = {1'b0, req_code} < NUM_SLAVES_C;

  // One-hot decode of the incoming block code; all-zero for out-of-range codes.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    sel_d = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_d[i] = (req_code == CODE_W'(i));
    end
  end

  // Response match from the selected slave only, of the latched operation type.
  always_comb begin
    slv_match = is_wr_q ? |(slv_wr_valid & sel_q) : |(slv_rd_valid & sel_q);
    rd_mux    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | slv_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_ir) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_sync) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and the per-cycle actions that drive the datapath.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    fwd      = 1'b0;
    srst_hit = 1'b0;
    dec_err  = 1'b0;
    slv_hit  = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (!code_ok) begin
            dec_err = 1'b1;
            state_d = RESP;
          end else if (lb_wr_en && (req_local == SRST_REG_ADDR)) begin
            srst_hit = 1'b1;
            state_d  = RESP;
          end else begin
            fwd     = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A valid arriving on the last allowed cycle still wins over the timeout.
        if (slv_match) begin
          slv_hit = 1'b1;
          state_d = RESP;
        end else if (tmo_cnt == TMO_MAX) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_now = dec_err | srst_hit | slv_hit | tmo_hit;
    resp_wr  = (state_q == IDLE) ? lb_wr_en : is_wr_q;
    resp_err = dec_err | tmo_hit;
  end

  // Request latch, one-cycle strobes, timeout counter and registered LB response.
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      sel_q       <= '0;
      is_wr_q     <= 1'b0;
      tmo_cnt     <= '0;
      slv_addr    <= '0;
      slv_wr_data <= '0;
      slv_rd_en   <= '0;
      slv_wr_en   <= '0;
      lb_rd_valid <= 1'b0;
      lb_wr_valid <= 1'b0;
      lb_err      <= 1'b0;
      lb_rd_data  <= '0;
    end else begin
      slv_rd_en   <= '0;
      slv_wr_en   <= '0;
      lb_rd_valid <= resp_now & ~resp_wr;
      lb_wr_valid <= resp_now & resp_wr;
      lb_err      <= resp_now & resp_err;

      if (accept) begin
        sel_q       <= sel_d;
        is_wr_q     <= lb_wr_en;
        slv_addr    <= req_local;
        slv_wr_data <= lb_wr_data;
      end

      if (fwd) begin
        slv_wr_en <= lb_wr_en ? sel_d : '0;
        slv_rd_en <= lb_wr_en ? '0 : sel_d;
        tmo_cnt   <= '0;
      end else if (state_q == WAIT && !slv_hit && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (resp_now && !resp_wr) begin
        lb_rd_data <= resp_err ? ERR_DATA : rd_mux;
      end
    end
  end

  // Per-slave soft-reset counters: reload on trigger, otherwise count down to zero.
  always_ff @(posedge clk_ir) begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      // NOTE: this counter array is a few flops rather than a RAM, so it is reset like any register.
      if (rst_sync)                  srst_cnt[i] <= '0;
      else if (srst_hit && sel_d[i]) srst_cnt[i] <= SRST_LOAD;
      else if (srst_cnt[i] != '0)    srst_cnt[i] <= srst_cnt[i] - SRST_W'(1);
    end
  end

  // Soft reset is held on for every slave while the router itself is in reset.
  always_comb begin
    slv_rst = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_rst[i] = rst_sync | (srst_cnt[i] != '0);
    end
  end

endmodule

// File: tb/tb_syn_lb_router.sv
// Directed bench for syn_lb_router: a table of single transactions plus
// hand-written sequences for soft reset, timeout, stray valids and reset abort.
module tb_syn_lb_router;

  logic         clk_ir = 1'b0;
  logic         rst_sync;
  logic         lb_rd_en, lb_wr_en;
  logic [11:0]  lb_addr;
  logic [31:0]  lb_wr_data;
  logic         lb_rd_valid, lb_wr_valid, lb_err;
  logic [31:0]  lb_rd_data;
  logic [3:0]   slv_rd_en, slv_wr_en;
  logic [7:0]   slv_addr;
  logic [31:0]  slv_wr_data;
  logic [3:0]   slv_rd_valid, slv_wr_valid;
  logic [127:0] slv_rd_data;
  logic [3:0]   slv_rst;

  int n_checks = 0;
  int n_pass   = 0;

  syn_lb_router #(
    .NUM_SLAVES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_ir(clk_ir),
    .rst_sync(rst_sync),
    .lb_rd_en(lb_rd_en),
    .lb_wr_en(lb_wr_en),
    .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data),
    .lb_rd_valid(lb_rd_valid),
    .lb_wr_valid(lb_wr_valid),
    .lb_rd_data(lb_rd_data),
    .lb_err(lb_err),
    .slv_rd_en(slv_rd_en),
    .slv_wr_en(slv_wr_en),
    .slv_addr(slv_addr),
    .slv_wr_data(slv_wr_data),
    .slv_rd_valid(slv_rd_valid),
    .slv_wr_valid(slv_wr_valid),
    .slv_rd_data(slv_rd_data),
    .slv_rst(slv_rst)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          k;            // slave response delay after the strobe, -1 = none
    logic [31:0] sdata;
    logic [3:0]  exp_rd_en;
    logic [3:0]  exp_wr_en;
    int          exp_lat;      // cycles from request to LB response
    logic        exp_err;
    logic [31:0] exp_rd_data;  // lb_rd_data at the response (holds on writes)
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int  code;
    logic early;
    logic is_wr;
    code  = int'(v.addr[11:8]);
    is_wr = v.wr;
    early = 1'b0;
    if (code < 4 && !is_wr) slv_rd_data[code*32 +: 32] = v.sdata;
    lb_rd_en   = v.rd;
    lb_wr_en   = v.wr;
    lb_addr    = v.addr;
    lb_wr_data = v.wdata;
    step();
    lb_rd_en = 1'b0;
    lb_wr_en = 1'b0;
    check({tag, "_rd_en"}, 32'(slv_rd_en), 32'(v.exp_rd_en));
    check({tag, "_wr_en"}, 32'(slv_wr_en), 32'(v.exp_wr_en));
    check({tag, "_slv_addr"}, 32'(slv_addr), 32'(v.addr[7:0]));
    check({tag, "_slv_wdata"}, slv_wr_data, v.wdata);
    for (int c = 1; c < v.exp_lat; c++) begin
      slv_rd_valid = '0;
      slv_wr_valid = '0;
      if (v.k >= 0 && c == 1 + v.k && code < 4) begin
        if (is_wr) slv_wr_valid[code] = 1'b1;
        else       slv_rd_valid[code] = 1'b1;
      end
      early = early | lb_rd_valid | lb_wr_valid;
      step();
    end
    slv_rd_valid = '0;
    slv_wr_valid = '0;
    check({tag, "_no_early"}, 32'(early), 32'd0);
    check({tag, "_rd_valid"}, 32'(lb_rd_valid), 32'(!is_wr));
    check({tag, "_wr_valid"}, 32'(lb_wr_valid), 32'(is_wr));
    check({tag, "_err"}, 32'(lb_err), 32'(v.exp_err));
    check({tag, "_rd_data"}, lb_rd_data, v.exp_rd_data);
    step();
    check({tag, "_idle_quiet"}, 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_rst;

    vecs[0] = '{1'b1, 1'b0, 12'h210, 32'h0,        2, 32'hCAFE0001, 4'b0100, 4'b0000, 4, 1'b0, 32'hCAFE0001};
    vecs[1] = '{1'b0, 1'b1, 12'h034, 32'h12345678, 0, 32'h0,        4'b0000, 4'b0001, 2, 1'b0, 32'hCAFE0001};
    vecs[2] = '{1'b1, 1'b0, 12'h37F, 32'h0,        0, 32'hA5A55A5A, 4'b1000, 4'b0000, 2, 1'b0, 32'hA5A55A5A};
    vecs[3] = '{1'b1, 1'b0, 12'h500, 32'h0,       -1, 32'h0,        4'b0000, 4'b0000, 1, 1'b1, 32'hDEADDEAD};
    vecs[4] = '{1'b0, 1'b1, 12'hF10, 32'h11112222,-1, 32'h0,        4'b0000, 4'b0000, 1, 1'b1, 32'hDEADDEAD};
    vecs[5] = '{1'b1, 1'b1, 12'h120, 32'h0BADF00D, 1, 32'h0,        4'b0000, 4'b0010, 3, 1'b0, 32'hDEADDEAD};
    vecs[6] = '{1'b1, 1'b0, 12'h1FF, 32'h0,        0, 32'h600DBEEF, 4'b0010, 4'b0000, 2, 1'b0, 32'h600DBEEF};
    vecs[7] = '{1'b1, 1'b0, 12'h400, 32'h0,       -1, 32'h0,        4'b0000, 4'b0000, 1, 1'b1, 32'hDEADDEAD};

    rst_sync     = 1'b1;
    lb_rd_en     = 1'b0;
    lb_wr_en     = 1'b0;
    lb_addr      = '0;
    lb_wr_data   = '0;
    slv_rd_valid = '0;
    slv_wr_valid = '0;
    for (int i = 0; i < 4; i++) slv_rd_data[i*32 +: 32] = 32'hB0B00000 | 32'(i);

    // Reset state.
    #1;
    check("rst_slv_rst_async_view", 32'(slv_rst), 32'hF);
    step();
    step();
    check("rst_lb_valids", 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
    check("rst_slv_strobes", 32'({slv_rd_en, slv_wr_en}), 32'd0);
    check("rst_lb_rd_data", lb_rd_data, 32'd0);
    check("rst_slv_addr", 32'(slv_addr), 32'd0);
    check("rst_slv_wr_data", slv_wr_data, 32'd0);
    check("rst_slv_rst", 32'(slv_rst), 32'hF);
    rst_sync = 1'b0;
    step();
    check("post_rst_slv_rst", 32'(slv_rst), 32'h0);

    // Table-driven single transactions.
    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Soft-reset write: immediate response, 4-cycle pulse on slave 1 only.
    lb_wr_en = 1'b1;
    lb_addr  = 12'h1FF;
    step();
    lb_wr_en = 1'b0;
    check("srst_wr_valid", 32'(lb_wr_valid), 32'd1);
    check("srst_no_err", 32'(lb_err), 32'd0);
    check("srst_no_strobe", 32'(slv_wr_en), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      exp_rst = (c <= 4) ? 4'b0010 : 4'b0000;
      check($sformatf("srst_pulse_c%0d", c), 32'(slv_rst), 32'(exp_rst));
      step();
    end

    // Soft-reset re-trigger at pulse cycle 3 stretches the pulse.
    lb_wr_en = 1'b1;
    lb_addr  = 12'h1FF;
    step();
    lb_wr_en = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        lb_wr_en = 1'b1;
        lb_addr  = 12'h1FF;
      end else begin
        lb_wr_en = 1'b0;
      end
      exp_rst = (c <= 7) ? 4'b0010 : 4'b0000;
      check($sformatf("srst_ext_c%0d", c), 32'(slv_rst), 32'(exp_rst));
      if (c == 4) check("srst_ext_wr_valid", 32'(lb_wr_valid), 32'd1);
      step();
    end
    lb_wr_en = 1'b0;

    // Timeout on slave 3 with a wrong-type valid in the middle, then a late valid.
    begin
      logic early;
      early      = 1'b0;
      lb_wr_en   = 1'b1;
      lb_addr    = 12'h340;
      lb_wr_data = 32'h00000055;
      step();
      lb_wr_en = 1'b0;
      check("tmo_strobe", 32'(slv_wr_en), 32'b1000);
      for (int c = 1; c < 10; c++) begin
        slv_rd_valid = (c == 2) ? 4'b1000 : 4'b0000;
        early = early | lb_wr_valid | lb_rd_valid;
        step();
      end
      slv_rd_valid = '0;
      check("tmo_no_early", 32'(early), 32'd0);
      check("tmo_wr_valid", 32'(lb_wr_valid), 32'd1);
      check("tmo_err", 32'(lb_err), 32'd1);
      check("tmo_rd_valid", 32'(lb_rd_valid), 32'd0);
      step();
      slv_wr_valid = 4'b1000;
      step();
      slv_wr_valid = '0;
      check("tmo_late_ignored_a", 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
      step();
      check("tmo_late_ignored_b", 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
    end

    // Stray valid from slave 1 and a second request while waiting on slave 0.
    lb_rd_en = 1'b1;
    lb_addr  = 12'h008;
    slv_rd_data[0 +: 32]  = 32'h00000ABC;
    slv_rd_data[32 +: 32] = 32'h11110BAD;
    step();
    check("stray_strobe", 32'(slv_rd_en), 32'b0001);
    lb_rd_en     = 1'b1;
    lb_addr      = 12'h200;
    slv_rd_valid = 4'b0010;
    step();
    lb_rd_en     = 1'b0;
    slv_rd_valid = '0;
    check("stray_no_resp", 32'({lb_rd_valid, lb_err}), 32'd0);
    check("stray_dropped_req", 32'(slv_rd_en), 32'd0);
    slv_rd_valid = 4'b0001;
    step();
    slv_rd_valid = '0;
    check("stray_resp_valid", 32'(lb_rd_valid), 32'd1);
    check("stray_resp_data", lb_rd_data, 32'h00000ABC);
    check("stray_resp_err", 32'(lb_err), 32'd0);
    step();
    check("stray_after", 32'({lb_rd_valid, slv_rd_en}), 32'd0);

    // Reset asserted during WAIT aborts the transaction.
    lb_rd_en = 1'b1;
    lb_addr  = 12'h200;
    step();
    lb_rd_en = 1'b0;
    check("abort_strobe", 32'(slv_rd_en), 32'b0100);
    step();
    rst_sync     = 1'b1;
    slv_rd_valid = 4'b0100;
    #1;
    check("abort_slv_rst_high", 32'(slv_rst), 32'hF);
    step();
    slv_rd_valid = '0;
    check("abort_no_resp", 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
    check("abort_strobes_low", 32'({slv_rd_en, slv_wr_en}), 32'd0);
    check("abort_rd_data_cleared", lb_rd_data, 32'd0);
    check("abort_slv_rst_held", 32'(slv_rst), 32'hF);
    rst_sync = 1'b0;
    step();
    check("abort_slv_rst_release", 32'(slv_rst), 32'h0);
    check("abort_still_quiet", 32'({lb_rd_valid, lb_wr_valid, lb_err}), 32'd0);
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 12'h244, 32'h0, 1, 32'h12340002, 4'b0100, 4'b0000, 3, 1'b0, 32'h12340002};
      run_vec("post_abort", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
